// File: rtl/prbs_pkg.sv
// Shared types and helpers for the serial PRBS checker: FSM state, tap
// positions per polynomial order, and the legal-order predicate.
package prbs_pkg;

   typedef enum logic {HUNT, LOCK} prbs_state_t;

   typedef struct packed {
      logic [5:0] tap_a;
      logic [5:0] tap_b;
   } prbs_taps_t;

   function automatic bit prbs_order_legal(input int order);
      return (order == 7) || (order == 15) || (order == 23) || (order == 31);
   endfunction

   // Feedback taps as 1-based stage numbers of x^A + x^B + 1.
   function automatic prbs_taps_t prbs_taps(input int order);
      prbs_taps_t t;
      case (order)
         15:      t = '{tap_a: 6'd15, tap_b: 6'd14};
         23:      t = '{tap_a: 6'd23, tap_b: 6'd18};
         31:      t = '{tap_a: 6'd31, tap_b: 6'd28};
         default: t = '{tap_a: 6'd7,  tap_b: 6'd6};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating event counter with synchronous clear; a clear that coincides
// with an increment leaves the count at 1.
module prbs_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= {{(WIDTH-1){1'b0}}, inc};
      end else if (inc) begin
         cnt <= sat_inc(cnt);
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-7/15/23/31 bit checker with lock/unlock FSM and
// saturating error/bit counters. Optional bit counter: PRBS_CHK_BIT_CNT_EN.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int PRBS_ORDER = 7,
   parameter int LOCK_CNT   = 16,
   parameter int WIN_LEN    = 64,
   parameter int UNLOCK_ERR = 4,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_i,
   input  logic             data_vld_i,
   input  logic             clr_i,
   output logic             lock_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [ERR_W-1:0] bit_cnt_o
);

   localparam prbs_taps_t TAPS = prbs_taps(PRBS_ORDER);
   localparam int TAP_A   = int'(TAPS.tap_a);
   localparam int TAP_B   = int'(TAPS.tap_b);
   localparam int FILL_W  = $clog2(PRBS_ORDER + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);
   localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

   if (!prbs_order_legal(PRBS_ORDER)) begin : g_bad_order
      $error("prbs_checker: PRBS_ORDER %0d is not one of 7/15/23/31", PRBS_ORDER);
   end
   if ((LOCK_CNT < 1) || (LOCK_CNT > 255)) begin : g_bad_lock_cnt
      $error("prbs_checker: LOCK_CNT %0d outside 1..255", LOCK_CNT);
   end

   prbs_state_t           state, state_nxt;
   logic [PRBS_ORDER-1:0] sr, sr_nxt;
   logic [FILL_W-1:0]     fill_cnt, fill_nxt;
   logic [MATCH_W-1:0]    match_cnt, match_nxt, match_inc;
   logic [WIN_W-1:0]      win_cnt, win_nxt, win_inc;
   logic [WERR_W-1:0]     werr_cnt, werr_nxt, werr_inc;
   logic                  pred_p0, mism_p0, sr_zero_p0, err_nxt;
   logic                  err_p1, clr_p1;

   // Stage p0: prediction and compare against the bit being consumed.
   assign pred_p0    = sr[TAP_A-1] ^ sr[TAP_B-1];
   assign mism_p0    = data_i ^ pred_p0;
   assign sr_zero_p0 = (sr == '0);
   assign match_inc  = match_cnt + 1'b1;
   assign win_inc    = win_cnt + 1'b1;
   assign werr_inc   = werr_cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      fill_nxt  = fill_cnt;
      match_nxt = match_cnt;
      win_nxt   = win_cnt;
      werr_nxt  = werr_cnt;
      err_nxt   = 1'b0;
      if (data_vld_i) begin
         case (state)
            HUNT: begin
               sr_nxt = {sr[PRBS_ORDER-2:0], data_i};
               if (fill_cnt != FILL_W'(PRBS_ORDER)) begin
                  fill_nxt = fill_cnt + 1'b1;
               end else if (sr_zero_p0 || mism_p0) begin
                  match_nxt = '0;
               end else if (match_inc == MATCH_W'(LOCK_CNT)) begin
                  state_nxt = LOCK;
                  match_nxt = '0;
                  win_nxt   = '0;
                  werr_nxt  = '0;
               end else begin
                  match_nxt = match_inc;
               end
            end
            LOCK: begin
               // Free-running generator: a corrupted bit never enters sr.
               sr_nxt  = {sr[PRBS_ORDER-2:0], pred_p0};
               err_nxt = mism_p0;
               if (mism_p0 && (werr_inc == WERR_W'(UNLOCK_ERR))) begin
                  state_nxt = HUNT;
                  fill_nxt  = '0;
                  match_nxt = '0;
               end else if (win_inc == WIN_W'(WIN_LEN)) begin
                  win_nxt  = '0;
                  werr_nxt = '0;
               end else begin
                  win_nxt  = win_inc;
                  werr_nxt = mism_p0 ? werr_inc : werr_cnt;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         sr        <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         werr_cnt  <= '0;
         err_p1    <= 1'b0;
         clr_p1    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         fill_cnt  <= fill_nxt;
         match_cnt <= match_nxt;
         win_cnt   <= win_nxt;
         werr_cnt  <= werr_nxt;
         err_p1    <= err_nxt;
         clr_p1    <= clr_i;
         err_o     <= err_p1;
      end
   end

   assign lock_o = (state == LOCK);

   // Stage p1: clear travels with the event it may coincide with.
   prbs_sat_cnt #(.WIDTH(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_p1),
      .clr (clr_p1),
      .cnt (err_cnt_o)
   );

`ifdef PRBS_CHK_BIT_CNT_EN
   logic chk_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_p1 <= 1'b0;
      end else begin
         chk_p1 <= data_vld_i && (state == LOCK);
      end
   end

   prbs_sat_cnt #(.WIDTH(ERR_W)) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .inc (chk_p1),
      .clr (clr_p1),
      .cnt (bit_cnt_o)
   );
`else
   assign bit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: queue-based reference model, two DUT
// instances (ERR_W=16 and ERR_W=4) sharing one stimulus stream.
module tb_prbs_checker;

   localparam int ORDER = 7;
   localparam int TA    = 7;
   localparam int TB    = 6;
   localparam int LOCKN = 16;
   localparam int WIN   = 64;
   localparam int UNL   = 4;
`ifdef PRBS_CHK_BIT_CNT_EN
   localparam bit BCNT_EN = 1'b1;
`else
   localparam bit BCNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_i = 1'b0;
   logic        data_vld_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        lock_a, err_a, lock_b, err_b;
   logic [15:0] ecnt_a, bcnt_a;
   logic [3:0]  ecnt_b, bcnt_b;

   always #5 clk = ~clk;

   prbs_checker #(.PRBS_ORDER(ORDER), .LOCK_CNT(LOCKN), .WIN_LEN(WIN),
                  .UNLOCK_ERR(UNL), .ERR_W(16)) dut_a (
      .clk(clk), .rst(rst), .data_i(data_i), .data_vld_i(data_vld_i),
      .clr_i(clr_i), .lock_o(lock_a), .err_o(err_a),
      .err_cnt_o(ecnt_a), .bit_cnt_o(bcnt_a));

   prbs_checker #(.PRBS_ORDER(ORDER), .LOCK_CNT(LOCKN), .WIN_LEN(WIN),
                  .UNLOCK_ERR(UNL), .ERR_W(4)) dut_b (
      .clk(clk), .rst(rst), .data_i(data_i), .data_vld_i(data_vld_i),
      .clr_i(clr_i), .lock_o(lock_b), .err_o(err_b),
      .err_cnt_o(ecnt_b), .bit_cnt_o(bcnt_b));

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: history of the last ORDER sequence bits, oldest first.
   typedef struct {
      bit rst;
      bit lock;
      bit err;
      int e16, b16, e4, b4;
   } exp_t;

   exp_t sb_q[$];
   bit   m_hist[$];
   bit   m_lock;
   int   m_fill, m_run, m_win, m_werr;
   int   m_e16, m_b16, m_e4, m_b4;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_step(input bit r, input bit v, input bit d, input bit c);
      exp_t x;
      bit   e = 1'b0;
      bit   b = 1'b0;
      if (r) begin
         m_hist = {};
         repeat (ORDER) m_hist.push_back(1'b0);
         m_lock = 1'b0;
         m_fill = 0; m_run = 0; m_win = 0; m_werr = 0;
         m_e16 = 0; m_b16 = 0; m_e4 = 0; m_b4 = 0;
      end else begin
         if (v) begin
            bit pred = m_hist[ORDER-TA] ^ m_hist[ORDER-TB];
            bit mis  = d ^ pred;
            bit zero = 1'b1;
            foreach (m_hist[k]) if (m_hist[k]) zero = 1'b0;
            if (!m_lock) begin
               m_hist.push_back(d);
               void'(m_hist.pop_front());
               if (m_fill < ORDER) m_fill++;
               else if (zero || mis) m_run = 0;
               else begin
                  m_run++;
                  if (m_run == LOCKN) begin
                     m_lock = 1'b1; m_run = 0; m_win = 0; m_werr = 0;
                  end
               end
            end else begin
               m_hist.push_back(pred);
               void'(m_hist.pop_front());
               b = 1'b1;
               e = mis;
               m_win++;
               if (mis) m_werr++;
               if (m_werr == UNL) begin
                  m_lock = 1'b0; m_fill = 0; m_run = 0;
               end else if (m_win == WIN) begin
                  m_win = 0; m_werr = 0;
               end
            end
         end
         if (c) begin
            m_e16 = e; m_e4 = e; m_b16 = b; m_b4 = b;
         end else begin
            m_e16 = sat(m_e16 + e, 65535); m_e4 = sat(m_e4 + e, 15);
            m_b16 = sat(m_b16 + b, 65535); m_b4 = sat(m_b4 + b, 15);
         end
         if (!BCNT_EN) begin
            m_b16 = 0; m_b4 = 0;
         end
      end
      x = '{r, m_lock, e, m_e16, m_b16, m_e4, m_b4};
      sb_q.push_back(x);
   endtask

   task automatic drive(input bit r, input bit v, input bit d, input bit c);
      @(negedge clk);
      rst = r; data_vld_i = v; data_i = d; clr_i = c;
      model_step(r, v, d, c);
      @(posedge clk);
      #1;
   endtask

   // Monitor: lock is due after the consuming edge, the rest one edge later.
   exp_t cur, prev;
   bit   prev_ok = 1'b0;

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         chk("sb_lock_a", lock_a, cur.lock);
         chk("sb_lock_b", lock_b, cur.lock);
         if (cur.rst) begin
            chk("sb_rst_err", err_a, 0);
            chk("sb_rst_ecnt", ecnt_a, 0);
            chk("sb_rst_bcnt", bcnt_a, 0);
         end else if (prev_ok) begin
            chk("sb_err_a", err_a, prev.err);
            chk("sb_err_b", err_b, prev.err);
            chk("sb_ecnt_a", ecnt_a, prev.e16);
            chk("sb_bcnt_a", bcnt_a, prev.b16);
            chk("sb_ecnt_b", ecnt_b, prev.e4);
            chk("sb_bcnt_b", bcnt_b, prev.b4);
         end
         prev    = cur;
         prev_ok = 1'b1;
      end
   end

   logic [6:0] g;

   task automatic gen(output bit b);
      b = g[6] ^ g[5];
      g = {g[5:0], b};
   endtask

   task automatic relock(input string tag);
      int n   = 0;
      int idx = -1;
      g = 7'($urandom_range(1, 127));
      for (int i = 0; i < 100 && idx < 0; i++) begin
         bit b;
         if ($urandom_range(0, 4) == 0) drive(1'b0, 1'b0, 1'($urandom), 1'b0);
         gen(b);
         drive(1'b0, 1'b1, b, 1'b0);
         if (lock_a && idx < 0) idx = n;
         n++;
      end
      chk(tag, idx, 22);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lock_idx, pulses, drop;
      bit min_lock, any_lock, b;

      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (50) drive(1'b0, 1'b0, 1'($urandom), 1'b0);
      chk("idle_lock", lock_a, 0);
      chk("idle_err", err_a, 0);
      chk("idle_ecnt", ecnt_a, 0);
      chk("idle_bcnt", bcnt_a, 0);

      // Clean PRBS-7, seed all-ones, back-to-back valid bits.
      g = 7'h7F;
      lock_idx = -1;
      for (int i = 0; i < 200; i++) begin
         gen(b);
         drive(1'b0, 1'b1, b, 1'b0);
         if (lock_a && lock_idx < 0) lock_idx = i;
      end
      chk("clean_lock_idx", lock_idx, 22);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("clean_ecnt", ecnt_a, 0);
      chk("clean_bcnt", bcnt_a, BCNT_EN ? 177 : 0);

      // Single inverted bit with random valid gaps.
      pulses = 0;
      min_lock = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 1'b0, 1'($urandom), 1'b0);
            pulses += int'(err_a);
            min_lock &= lock_a;
         end
         gen(b);
         if (i == 100) b = ~b;
         drive(1'b0, 1'b1, b, 1'b0);
         pulses += int'(err_a);
         min_lock &= lock_a;
      end
      repeat (2) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         pulses += int'(err_a);
      end
      chk("flip_pulses", pulses, 1);
      chk("flip_ecnt", ecnt_a, 1);
      chk("flip_lock_held", min_lock, 1);

      // Stuck-zero input, with gaps carrying ones that must be ignored.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      any_lock = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0) drive(1'b0, 1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         any_lock |= lock_a;
      end
      chk("zero_never_lock", any_lock, 0);

      // Lock / random-data unlock episodes accumulate errors past 4-bit saturation.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int ep = 0; ep < 6; ep++) begin
         relock("ep_relock_idx");
         drop = -1;
         for (int i = 1; i <= 200 && drop < 0; i++) begin
            drive(1'b0, 1'b1, 1'($urandom), 1'b0);
            if (!lock_a) drop = i;
         end
         chk("ep_unlock_le64", (drop >= 1 && drop <= WIN) ? 1 : 0, 1);
      end
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat4_ecnt", ecnt_b, 15);
      chk("ecnt16_ge20", (ecnt_a >= 20) ? 1 : 0, 1);

      // Clear coinciding with a mismatched bit.
      relock("clr_relock_idx");
      gen(b);
      drive(1'b0, 1'b1, ~b, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("clr_ecnt", ecnt_a, 1);
      chk("clr_keeps_lock", lock_a, 1);

      // Reset mid-LOCK, then relock from scratch.
      repeat (5) begin
         gen(b);
         drive(1'b0, 1'b1, b, 1'b0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_lock", lock_a, 0);
      chk("rst_ecnt", ecnt_a, 0);
      chk("rst_bcnt", bcnt_a, 0);
      relock("rst_relock_idx");
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
